// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices, issue FSM states and command layout for the ALU issue stage.
package alu_pkg;

    localparam logic [3:0] OP_ADDSUB = 4'b0000;
    localparam logic [3:0] OP_MUL    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;
    localparam logic [3:0] OP_XOR    = 4'b1010;
    localparam logic [3:0] OP_NOT    = 4'b1100;
    localparam logic [3:0] OP_SHL    = 4'b0100;
    localparam logic [3:0] OP_SHR    = 4'b0101;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_SIGN  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [3:0] op;
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } alu_cmd_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADDSUB, OP_MUL, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage; extra pointer bit separates full from empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU commands, issues them on registered operand lines and captures the result.
// Optional ALU_ISSUE_STATS_EN adds saturating stat_ops / stat_ovf counters.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// EXEC  | operands driven on alu_*, ALU settling this cycle
// RESP  | response held on rsp_* until the consumer takes it
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic            cmd_sub,
    input  logic [7:0]      cmd_a,
    input  logic [7:0]      cmd_b,
    input  logic            cmd_use_acc,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [OP_W-1:0] alu_sel,
    output logic            alu_sub,
    input  logic [7:0]      alu_out,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            alu_ovf,
    input  logic            alu_sign,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_result,
    output logic [3:0]      rsp_flags,
    output logic            rsp_err,
    output logic [7:0]      acc
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]     stat_ops,
    output logic [15:0]     stat_ovf
`endif
);

    issue_state_e state;
    alu_cmd_t     push_cmd;
    alu_cmd_t     head_cmd;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic         rsp_fire;

    assign cmd_ready = rst_n & ~fifo_full;
    assign push_cmd  = '{op: cmd_op, sub: cmd_sub, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign fifo_pop  = ~fifo_empty & ((state == IDLE) | ((state == RESP) & rsp_fire));

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(alu_cmd_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid & cmd_ready),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            alu_sub    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            acc        <= '0;
        end else begin
            // acc is already final for the previous command whenever a pop happens.
            if (fifo_pop) begin
                alu_a   <= head_cmd.use_acc ? acc : head_cmd.a;
                alu_b   <= head_cmd.b;
                alu_sel <= head_cmd.op;
                alu_sub <= head_cmd.sub;
            end
            unique case (state)
                IDLE: begin
                    if (fifo_pop) state <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    rsp_flags  <= {alu_sign, alu_ovf, alu_zero, alu_carry};
                    rsp_err    <= ~op_is_legal(alu_sel);
                    if (op_is_legal(alu_sel)) acc <= alu_out;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        state     <= fifo_pop ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (rsp_fire) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (rsp_flags[FLAG_OVF] && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed plan cases plus randomized traffic
// against a transaction-level model; also models the downstream ALU.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_sub, cmd_use_acc;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_sub, alu_carry, alu_zero, alu_ovf, alu_sign;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_result, acc;
    logic [3:0] rsp_flags;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops, stat_ovf;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sub(cmd_sub),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
    );

    // Downstream ALU: returns {sign, ovf, zero, carry, result}.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op, input logic sub);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r, bb;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = 8'h00; s = 9'h000; p = 16'h0000;
        bb = sub ? ~b : b;
        case (op)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, bb} + {8'h00, sub};
                r = s[7:0]; c = s[8];
                v = (a[7] == bb[7]) && (r[7] != a[7]);
            end
            4'b0010: begin p = {8'h00, a} * {8'h00, b}; r = p[15:8]; c = |p[15:8]; end
            4'b1000: r = a & b;
            4'b1001: r = a | b;
            4'b1010: r = a ^ b;
            4'b1100: r = ~a;
            4'b0100: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'b0101: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: r = ~(a & b);
        endcase
        return {r[7], v, (r == 8'h00), c, r};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h2, 4'h8, 4'h9, 4'hA, 4'hC, 4'h4, 4'h5};
    endfunction

    logic [11:0] alu_res;
    assign alu_res   = alu_ref(alu_a, alu_b, alu_sel, alu_sub);
    assign alu_out   = alu_res[7:0];
    assign alu_carry = alu_res[8];
    assign alu_zero  = alu_res[9];
    assign alu_ovf   = alu_res[10];
    assign alu_sign  = alu_res[11];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
        logic [7:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          hs_count = 0;
    int          ovf_count = 0;
    logic [7:0]  model_acc = 8'h00;
    exp_t        m_e;
    logic [7:0]  m_a;
    logic [11:0] m_r;

    always @(posedge clk) cyc++;

    // Transaction model: responses come back in acceptance order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_acc = 8'h00;
            hs_count  = 0;
            ovf_count = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("rsp_extra", 32'(rsp_valid), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(m_e.res));
                    check("rsp_flags",  32'(rsp_flags),  32'(m_e.flags));
                    check("rsp_err",    32'(rsp_err),    32'(m_e.err));
                    check("acc",        32'(acc),        32'(m_e.acc));
                    hs_count++;
                    if (m_e.flags[2]) ovf_count++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                m_a       = cmd_use_acc ? model_acc : cmd_a;
                m_r       = alu_ref(m_a, cmd_b, cmd_op, cmd_sub);
                m_e.res   = m_r[7:0];
                m_e.flags = m_r[11:8];
                m_e.err   = !is_legal(cmd_op);
                if (!m_e.err) model_acc = m_r[7:0];
                m_e.acc   = model_acc;
                exp_q.push_back(m_e);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic sub, input logic [7:0] a,
                        input logic [7:0] b, input logic use_acc);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_sub = sub;
        cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] res, input logic [3:0] fl,
                              input logic err);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 32'(rsp_valid),  32'd1);
        check({tag, "_res"},   32'(rsp_result), 32'(res));
        check({tag, "_flags"}, 32'(rsp_flags),  32'(fl));
        check({tag, "_err"},   32'(rsp_err),    32'(err));
        @(posedge clk); #1;
    endtask

    logic [3:0] legal_ops [8];
    logic [11:0] ill_r;
    int accepted;
    int n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        legal_ops = '{4'h0, 4'h2, 4'h8, 4'h9, 4'hA, 4'hC, 4'h4, 4'h5};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_sub = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_alu",       32'({alu_a, alu_b, alu_sel, alu_sub}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Overflowing add with exact latency.
        send(4'h0, 1'b0, 8'h7F, 8'h01, 1'b0);
        @(negedge clk); check("lat_k0_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); check("lat_k1_valid", 32'(rsp_valid), 32'd0);
        check("lat_k1_alu_a", 32'(alu_a), 32'h7F);
        @(negedge clk); check("lat_k2_valid", 32'(rsp_valid), 32'd1);
        expect_rsp("add_ovf", 8'h80, 4'b1100, 1'b0);

        send(4'h0, 1'b1, 8'h05, 8'h05, 1'b0);
        expect_rsp("sub_zero", 8'h00, 4'b0011, 1'b0);

        // Accumulator chaining and an illegal op that must not touch acc.
        send(4'h0, 1'b0, 8'h10, 8'h20, 1'b0);
        expect_rsp("chain1", 8'h30, 4'b0000, 1'b0);
        check("chain1_acc", 32'(acc), 32'h30);
        send(4'h0, 1'b0, 8'h99, 8'h05, 1'b1);
        expect_rsp("chain2", 8'h35, 4'b0000, 1'b0);
        check("chain2_acc", 32'(acc), 32'h35);
        ill_r = alu_ref(8'h01, 8'h02, 4'h3, 1'b0);
        send(4'h3, 1'b0, 8'h01, 8'h02, 1'b0);
        expect_rsp("illegal", ill_r[7:0], ill_r[11:8], 1'b1);
        check("illegal_acc", 32'(acc), 32'h35);

        send(4'h2, 1'b0, 8'h30, 8'h50, 1'b0);
        expect_rsp("mul", 8'h0F, 4'b0001, 1'b0);
        send(4'h4, 1'b0, 8'h81, 8'h00, 1'b0);
        expect_rsp("shl", 8'h02, 4'b0001, 1'b0);

        // Backpressure: 1 in RESP + 4 in FIFO.
        rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1; cmd_op = 4'h8; cmd_sub = 1'b0; cmd_use_acc = 1'b0;
            cmd_a = 8'(8'hF0 | i); cmd_b = 8'(8'h1F - i);
            @(negedge clk);
            if (cmd_ready) accepted++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        hs_cyc.delete();
        rsp_ready = 1'b1;
        n = 0;
        while (hs_cyc.size() < 5 && n < 40) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("bp_rsp_count", 32'(hs_cyc.size()), 32'd5);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("bp_rsp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

`ifdef ALU_ISSUE_STATS_EN
        check("stat_ops", 32'(stat_ops), 32'(hs_count));
        check("stat_ovf", 32'(stat_ovf), 32'd1);
`endif

        // Reset while EXEC with 3 commands still queued.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'h9, 1'b0, 8'(i + 1), 8'h40, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("pre_rst_exec_alu_a", 32'(alu_a), 32'h02);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_rsp", 32'({rsp_valid, rsp_result, rsp_flags, rsp_err}), 32'd0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel, alu_sub}), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
`ifdef ALU_ISSUE_STATS_EN
        check("mid_rst_stats", 32'({stat_ops, stat_ovf}), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            check("post_rst_no_issue", 32'(alu_sel), 32'd0);
        end
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Randomized traffic against the model.
        @(posedge clk); #1;
        for (int i = 0; i < 800; i++) begin
            cmd_valid   = ($urandom_range(0, 2) != 0);
            cmd_op      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
            cmd_sub     = 1'($urandom_range(0, 1));
            cmd_a       = 8'($urandom);
            cmd_b       = 8'($urandom);
            cmd_use_acc = ($urandom_range(0, 3) == 0);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin @(negedge clk); n++; end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
`ifdef ALU_ISSUE_STATS_EN
        check("stat_ops_final", 32'(stat_ops), 32'(hs_count));
        check("stat_ovf_final", 32'(stat_ovf), 32'(ovf_count));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Sequential command front-end that sits directly upstream of the combinational 8-bit ALU and also captures its outputs. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time on registered ALU operand/select lines, captures the ALU result and flags one cycle later, and presents them on a valid/ready response interface. An accumulator register lets a command take operand A from the previous result.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
OP_W, 4, ALU select width; fixed to match ALU_Sel

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  FIFO can accept; = !full, forced 0 while rst_n low
cmd_op  in  4  ALU select code
cmd_sub  in  1  subtract control for the add/sub op
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_use_acc  in  1  replace cmd_a with the accumulator at issue
alu_a  out  8  registered operand to ALU A
alu_b  out  8  registered operand to ALU B
alu_sel  out  4  registered ALU_Sel
alu_sub  out  1  registered Sub
alu_out  in  8  ALU_Out
alu_carry, alu_zero, alu_ovf, alu_sign  in  1 each  ALU flags
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_result  out  8  captured result
rsp_flags  out  4  [0]carry [1]zero [2]overflow [3]sign
rsp_err  out  1  captured op was not a legal code
acc  out  8  accumulator value

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all alu_*, rsp_*, acc = 0. Reset mid-operation discards the FIFO contents, the in-flight op and any pending response. No response is emitted.
- Legal ops: 0000 add/sub, 0010 mul, 1000 and, 1001 or, 1010 xor, 1100 not, 0100 shl, 0101 shr. Any other code is issued anyway. Its response carries rsp_err=1 and whatever result/flags the ALU returns.
- FIFO push on cmd_valid && cmd_ready. No bypass: every command passes through the FIFO. If the FIFO is full, cmd_ready=0 and a simultaneous pop does not free space until the next cycle.
- FSM:
  - IDLE: if FIFO non-empty, pop, register alu_*, go to EXEC.
  - EXEC: one cycle for the ALU to settle. At the clock edge, capture alu_out/flags/err into rsp_*. If the op is legal, acc <= alu_out. Go to RESP.
  - RESP: rsp_valid=1. All rsp_* are stable until the handshake. On rsp_valid && rsp_ready: if FIFO non-empty, pop and go to EXEC; otherwise go to IDLE.
- Latency: command accepted at edge k -> alu_* valid from edge k+1 -> rsp_valid from edge k+2.
- Throughput: one result per 2 cycles with rsp_ready held at 1.
- alu_* hold their last issued values while in IDLE/RESP.
- cmd_use_acc: alu_a <= acc sampled at the pop edge. acc already holds the previous legal result, so back-to-back chaining needs no forwarding.
- Capacity with rsp_ready=0: 1 command held in RESP + FIFO_DEPTH in the FIFO.
- FIFO pointers wrap modulo FIFO_DEPTH. Use a count or an extra pointer bit for full/empty.

Optional Feature:
ALU_ISSUE_STATS_EN: when defined, adds outputs stat_ops[15:0] and stat_ovf[15:0].
- stat_ops increments on each response handshake.
- stat_ovf increments on each response handshake with rsp_flags[2]=1.
- Both saturate at 0xFFFF and reset to 0.
When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADDSUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR), flag bit indices, FSM state enum (IDLE/EXEC/RESP), packed command struct {op, sub, a, b, use_acc}.
- One sub-module: alu_cmd_fifo, parameterised by depth and width, with push/pop/full/empty and asynchronous active-low reset.

Test Plan:
- Add A=0x7F, B=0x01, op=0000, sub=0 -> rsp_result=0x80, flags carry=0, zero=0, ovf=1, sign=1; rsp_valid exactly 2 edges after acceptance.
- Sub A=0x05, B=0x05, sub=1 -> result 0x00, zero=1, carry=1, err=0.
- Chain: add 0x10+0x20 -> 0x30, acc=0x30. Then use_acc=1, add B=0x05 -> 0x35. Then illegal op 0011 -> err=1 and acc stays 0x35.
- Backpressure: rsp_ready=0, push 7 commands back-to-back -> exactly 5 accepted (cmd_ready low after the 5th). Releasing rsp_ready -> 5 responses in order, one every 2 cycles.
- Mul A=0x30, B=0x50 -> 0x0F; shl A=0x81 -> 0x02. With ALU_ISSUE_STATS_EN defined, after all the above, stat_ops equals the handshake count and stat_ovf=1.
- Assert rst_n low during EXEC with 3 commands queued -> all outputs 0 immediately. After release: no response, FIFO empty, cmd_ready=1.
